oncozucu_kuyrugu: RTL and testbench
===================================

Name: oncozucu_kuyrugu

Overview:
Parametrised fetch-side predecoder with an instruction queue. Each cycle it accepts a packet of GENISLIK 32-bit instructions from the fetch unit and classifies every slot into an oncoz_pkg::dallanma_turu_t value (JAL, JALR, DALLANMA, DALLANMA_YOK). For JAL and conditional branches it computes the direct target and applies static prediction. When a slot is predicted taken, it raises a fetch redirect and discards the younger slots in that packet. Predecoded entries are buffered in a FIFO and handed one per cycle to decode over a valid/ready handshake.

Parameters:
GENISLIK, 2, instructions per fetch packet (1..4)
DERINLIK, 8, queue entries (power of two, >= 2*GENISLIK)
GERI_ALINIR, 1, 1 = backward conditional branches predicted taken (BTFN); 0 = all conditional branches predicted not-taken

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
temizle_i  input  1  flush; empties the queue
paket_gecerli_i  input  1  fetch packet valid
paket_hazir_o  output  1  queue can accept a packet
paket_pc_i  input  32  PC of slot 0
paket_buyruk_i  input  32*GENISLIK  slot k in bits [32k+31:32k]
paket_maske_i  input  GENISLIK  per-slot valid
cikis_gecerli_o  output  1  head entry valid
cikis_hazir_i  input  1  decode accepts head
cikis_buyruk_o  output  32  head instruction
cikis_pc_o  output  32  head PC
cikis_tur_o  output  dallanma_turu_t  head branch type
cikis_tahmin_o  output  1  head predicted taken
cikis_hedef_o  output  32  head predicted target (0 when not taken)
yonlendir_o  output  1  one-cycle fetch redirect pulse
yonlendir_pc_o  output  32  redirect target

Behaviour:
- Reset (rst_i sampled high at clk_i): queue empty, occupancy 0, pointers 0. cikis_gecerli_o=0, yonlendir_o=0, yonlendir_pc_o=0, paket_hazir_o=1 in the cycle after reset.
- Classification per slot follows RV32 encodings: JAL opcode -> JAL; JALR -> JALR; BEQ/BNE/BLT/BGE/BLTU/BGEU -> DALLANMA; anything else -> DALLANMA_YOK.
- Slot k PC = paket_pc_i + 4k, computed mod 2^32.
- Target: JAL uses pc + sext(J-imm); DALLANMA uses pc + sext(B-imm); both mod 2^32. JALR is never predicted (tahmin=0, hedef=0).
- Prediction: JAL is always taken. DALLANMA is taken iff GERI_ALINIR=1 and imm is negative. DALLANMA_YOK is never taken.
- paket_hazir_o = (free entries >= GENISLIK) && !temizle_i. It is combinational from registered occupancy.
- Accept = paket_gecerli_i && paket_hazir_o.
- On accept, valid slots (mask bit 1) are enqueued in slot order up to and including the first predicted-taken valid slot. Later slots are dropped.
- Push count per cycle ranges 0..GENISLIK. A packet with an all-zero mask is accepted with no push.
- Redirect: if an accepted packet contains a predicted-taken slot, yonlendir_o=1 and yonlendir_pc_o=target in the next cycle (registered, 1-cycle latency) for exactly one cycle. Otherwise yonlendir_o=0 and yonlendir_pc_o holds its last value.
- Output: cikis_* reflect the head entry, registered in the FIFO storage. Pop = cikis_gecerli_o && cikis_hazir_i.
- Push and pop may occur in the same cycle. Occupancy_next = occ + push_count - pop. A packet entering an empty queue is visible at the output the following cycle; there is no same-cycle bypass.
- Pointers wrap modulo DERINLIK. Occupancy width is $clog2(DERINLIK)+1 so that a full queue (occ=DERINLIK) is distinguishable from empty.
- Flush: temizle_i has priority over push, pop and redirect generation. In the next cycle occupancy=0 and cikis_gecerli_o=0. A packet presented in the flush cycle is not accepted (paket_hazir_o=0), and no redirect results from it.
- rst_i has priority over temizle_i.
- No overflow by construction. The design must assert (simulation only) that push never exceeds free entries and that pop is never taken from an empty queue.

Test Plan:
- Reset then idle -> cikis_gecerli_o=0, paket_hazir_o=1, yonlendir_o=0; no change for 10 cycles.
- GENISLIK=2, pc=0x100, slots {0x00000013, 0x00008067}, mask 11, cikis_hazir_i=1 -> two pops in order: (0x100, DALLANMA_YOK, tahmin 0), then (0x104, JALR, tahmin 0, hedef 0); no redirect.
- pc=0x200, slots {0x0080006F (jal x0,+8), 0x00000013}, mask 11 -> one entry only: (0x200, JAL, tahmin 1, hedef 0x208); yonlendir_o=1 with yonlendir_pc_o=0x208 exactly one cycle after accept; slot 1 never appears at the output.
- pc=0x300, slots {0x00000013, 0xFE000EE3 (beq -4)}: with GERI_ALINIR=1 -> second entry has tahmin 1, hedef 0x300, and a redirect to 0x300; with GERI_ALINIR=0 -> tahmin 0, no redirect.
- cikis_hazir_i=0, feed 4 two-slot packets into DERINLIK=8 -> occupancy 8 and paket_hazir_o=0. Then set cikis_hazir_i=1 for 2 cycles -> paket_hazir_o=1. Contents pop in FIFO order across the pointer wrap.
- Queue holding 5 entries, temizle_i=1 asserted together with a valid packet containing a JAL -> next cycle cikis_gecerli_o=0, yonlendir_o=0, and the packet is not accepted.

Source files
------------

// File: rtl/oncozucu_kuyrugu.sv
// Fetch-side predecoder: classifies each slot of a fetch packet, statically predicts
// direct branches, raises a fetch redirect and queues predecoded entries for decode.
package oncoz_pkg;
   typedef enum logic [1:0] {
      DALLANMA_YOK = 2'd0,
      JAL          = 2'd1,
      JALR         = 2'd2,
      DALLANMA     = 2'd3
   } dallanma_turu_t;

   typedef struct packed {
      logic [31:0]    buyruk;
      logic [31:0]    pc;
      dallanma_turu_t tur;
      logic           tahmin;
      logic [31:0]    hedef;
   } oncoz_giris_t;

   function automatic oncoz_giris_t oncoz_coz(input logic [31:0] pc,
                                              input logic [31:0] buyruk,
                                              input logic        geri_alinir);
      logic [31:0]  j_imm;
      logic [31:0]  b_imm;
      oncoz_giris_t g;
      j_imm    = {{12{buyruk[31]}}, buyruk[19:12], buyruk[20], buyruk[30:21], 1'b0};
      b_imm    = {{20{buyruk[31]}}, buyruk[7], buyruk[30:25], buyruk[11:8], 1'b0};
      g.buyruk = buyruk;
      g.pc     = pc;
      g.tur    = DALLANMA_YOK;
      g.tahmin = 1'b0;
      g.hedef  = '0;
      case (buyruk[6:0])
         7'b1101111: begin
            g.tur    = JAL;
            g.tahmin = 1'b1;
            g.hedef  = pc + j_imm;
         end
         7'b1100111: if (buyruk[14:12] == 3'b000) g.tur = JALR;
         // funct3 010/011 are not branch encodings
         7'b1100011: if (buyruk[14:13] != 2'b01) begin
            g.tur = DALLANMA;
            if (geri_alinir && buyruk[31]) begin
               g.tahmin = 1'b1;
               g.hedef  = pc + b_imm;
            end
         end
         default: ;
      endcase
      return g;
   endfunction
endpackage

module oncozucu_kuyrugu
   import oncoz_pkg::*;
#(
   parameter int GENISLIK    = 2,
   parameter int DERINLIK    = 8,
   parameter bit GERI_ALINIR = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    temizle_i,
   input  logic                    paket_gecerli_i,
   output logic                    paket_hazir_o,
   input  logic [31:0]             paket_pc_i,
   input  logic [32*GENISLIK-1:0]  paket_buyruk_i,
   input  logic [GENISLIK-1:0]     paket_maske_i,
   output logic                    cikis_gecerli_o,
   input  logic                    cikis_hazir_i,
   output logic [31:0]             cikis_buyruk_o,
   output logic [31:0]             cikis_pc_o,
   output dallanma_turu_t          cikis_tur_o,
   output logic                    cikis_tahmin_o,
   output logic [31:0]             cikis_hedef_o,
   output logic                    yonlendir_o,
   output logic [31:0]             yonlendir_pc_o
);
   localparam int AW = $clog2(DERINLIK);
   localparam int OW = AW + 1;

   oncoz_giris_t r_mem [DERINLIK];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [OW-1:0] r_occ;
   logic          r_yon;
   logic [31:0]   r_yon_pc;

   oncoz_giris_t  w_giris [GENISLIK];
   logic [AW-1:0] w_ofs   [GENISLIK];
   logic [GENISLIK-1:0] w_yaz;
   logic [OW-1:0] w_push_cnt;
   logic [OW-1:0] w_bos;
   logic          w_dur;
   logic          w_kabul;
   logic          w_pop;
   logic          w_yon;
   logic [31:0]   w_yon_pc;
   oncoz_giris_t  w_bas;

   assign w_bos           = OW'(DERINLIK) - r_occ;
   assign paket_hazir_o   = (w_bos >= OW'(GENISLIK)) && !temizle_i;
   assign w_kabul         = paket_gecerli_i && paket_hazir_o;
   assign cikis_gecerli_o = (r_occ != '0);
   assign w_pop           = cikis_gecerli_o && cikis_hazir_i;

   // Slots are packed densely after the write pointer; the first taken slot ends the packet.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      w_push_cnt = '0;
      w_dur      = 1'b0;
      w_yaz      = '0;
      w_yon      = 1'b0;
      w_yon_pc   = '0;
      for (int k = 0; k < GENISLIK; k++) begin
         w_giris[k] = oncoz_coz(paket_pc_i + 32'(4 * k), paket_buyruk_i[32*k +: 32], GERI_ALINIR);
         w_ofs[k]   = '0;
         if (w_kabul && paket_maske_i[k] && !w_dur) begin
            w_yaz[k]   = 1'b1;
            w_ofs[k]   = w_push_cnt[AW-1:0];
            w_push_cnt = w_push_cnt + OW'(1);
            if (w_giris[k].tahmin) begin
               w_dur    = 1'b1;
               w_yon    = 1'b1;
               w_yon_pc = w_giris[k].hedef;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr     <= '0;
         r_rd     <= '0;
         r_occ    <= '0;
         r_yon    <= 1'b0;
         r_yon_pc <= '0;
      end else if (temizle_i) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_occ <= '0;
         r_yon <= 1'b0;
      end else begin
         r_wr  <= r_wr + w_push_cnt[AW-1:0];
         r_rd  <= r_rd + AW'(w_pop);
         r_occ <= r_occ + w_push_cnt - OW'(w_pop);
         r_yon <= w_yon;
         if (w_yon) r_yon_pc <= w_yon_pc;
      end
   end

   // NOTE: storage is deliberately not reset; occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < GENISLIK; k++) begin
         if (w_yaz[k]) r_mem[r_wr + w_ofs[k]] <= w_giris[k];
      end
   end

   assign w_bas          = r_mem[r_rd];
   assign cikis_buyruk_o = w_bas.buyruk;
   assign cikis_pc_o     = w_bas.pc;
   assign cikis_tur_o    = w_bas.tur;
   assign cikis_tahmin_o = w_bas.tahmin;
   assign cikis_hedef_o  = w_bas.hedef;
   assign yonlendir_o    = r_yon;
   assign yonlendir_pc_o = r_yon_pc;

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (!rst_i && !temizle_i) begin
         assert (w_push_cnt <= w_bos);
         assert (!w_pop || (r_occ != '0));
      end
   end
`endif
endmodule

// File: tb/tb_oncozucu_kuyrugu.sv
// Scoreboard bench for oncozucu_kuyrugu: two instances (BTFN on / off) share stimulus,
// expected entries are queued when a packet is accepted and checked as decode pops them.
module tb_oncozucu_kuyrugu;
   import oncoz_pkg::*;

   localparam int GENISLIK = 2;
   localparam int DERINLIK = 8;
   localparam oncoz_giris_t BOS = '0;

   logic clk = 1'b0;
   logic rst_i;
   logic temizle_i;
   logic paket_gecerli_i;
   logic [31:0] paket_pc_i;
   logic [63:0] paket_buyruk_i;
   logic [1:0]  paket_maske_i;
   logic cikis_hazir_i;

   logic           paket_hazir   [2];
   logic           cikis_gecerli [2];
   logic [31:0]    cikis_buyruk  [2];
   logic [31:0]    cikis_pc      [2];
   dallanma_turu_t cikis_tur     [2];
   logic           cikis_tahmin  [2];
   logic [31:0]    cikis_hedef   [2];
   logic           yonlendir     [2];
   logic [31:0]    yonlendir_pc  [2];

   oncoz_giris_t sb [2][$];
   logic        yon_sonraki    [2];
   logic [31:0] yon_sonraki_pc [2];
   logic        yon_bek        [2];
   logic [31:0] son_pc         [2];

   int karsilastirilan = 0;
   int uyusmayan       = 0;

   always #5 clk = ~clk;

   oncozucu_kuyrugu #(.GENISLIK(GENISLIK), .DERINLIK(DERINLIK), .GERI_ALINIR(1'b1)) dut_a (
      .clk_i(clk), .rst_i(rst_i), .temizle_i(temizle_i),
      .paket_gecerli_i(paket_gecerli_i), .paket_hazir_o(paket_hazir[0]),
      .paket_pc_i(paket_pc_i), .paket_buyruk_i(paket_buyruk_i), .paket_maske_i(paket_maske_i),
      .cikis_gecerli_o(cikis_gecerli[0]), .cikis_hazir_i(cikis_hazir_i),
      .cikis_buyruk_o(cikis_buyruk[0]), .cikis_pc_o(cikis_pc[0]), .cikis_tur_o(cikis_tur[0]),
      .cikis_tahmin_o(cikis_tahmin[0]), .cikis_hedef_o(cikis_hedef[0]),
      .yonlendir_o(yonlendir[0]), .yonlendir_pc_o(yonlendir_pc[0]));

   oncozucu_kuyrugu #(.GENISLIK(GENISLIK), .DERINLIK(DERINLIK), .GERI_ALINIR(1'b0)) dut_b (
      .clk_i(clk), .rst_i(rst_i), .temizle_i(temizle_i),
      .paket_gecerli_i(paket_gecerli_i), .paket_hazir_o(paket_hazir[1]),
      .paket_pc_i(paket_pc_i), .paket_buyruk_i(paket_buyruk_i), .paket_maske_i(paket_maske_i),
      .cikis_gecerli_o(cikis_gecerli[1]), .cikis_hazir_i(cikis_hazir_i),
      .cikis_buyruk_o(cikis_buyruk[1]), .cikis_pc_o(cikis_pc[1]), .cikis_tur_o(cikis_tur[1]),
      .cikis_tahmin_o(cikis_tahmin[1]), .cikis_hedef_o(cikis_hedef[1]),
      .yonlendir_o(yonlendir[1]), .yonlendir_pc_o(yonlendir_pc[1]));

   task automatic check(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
      karsilastirilan++;
      if (gercek !== beklenen) begin
         uyusmayan++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", ad, gercek, beklenen, $time);
      end
   endtask

   function automatic oncoz_giris_t g(input logic [31:0] buyruk, input logic [31:0] pc,
                                      input dallanma_turu_t tur, input logic tahmin,
                                      input logic [31:0] hedef);
      oncoz_giris_t e;
      e.buyruk = buyruk;
      e.pc     = pc;
      e.tur    = tur;
      e.tahmin = tahmin;
      e.hedef  = hedef;
      return e;
   endfunction

   // Redirect expectation moves one clock after acceptance, like the DUT register.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst_i) begin
            yon_bek[d]     <= 1'b0;
            son_pc[d]      <= '0;
            yon_sonraki[d] <= 1'b0;
         end else begin
            yon_bek[d] <= yon_sonraki[d];
            if (yon_sonraki[d]) son_pc[d] <= yon_sonraki_pc[d];
            yon_sonraki[d] <= 1'b0;
         end
      end
   end

   // Monitor: compares outputs every negedge and pops the scoreboard on each handshake.
   always @(negedge clk) begin
      oncoz_giris_t e;
      for (int d = 0; d < 2; d++) begin
         if (rst_i) begin
            sb[d].delete();
         end else begin
            check($sformatf("d%0d_cikis_gecerli", d), 32'(cikis_gecerli[d]), 32'(sb[d].size() != 0));
            check($sformatf("d%0d_paket_hazir", d), 32'(paket_hazir[d]),
                  32'(((DERINLIK - sb[d].size()) >= GENISLIK) && !temizle_i));
            check($sformatf("d%0d_yonlendir", d), 32'(yonlendir[d]), 32'(yon_bek[d]));
            check($sformatf("d%0d_yonlendir_pc", d), yonlendir_pc[d], son_pc[d]);
            if (temizle_i) begin
               sb[d].delete();
            end else if (cikis_gecerli[d] && cikis_hazir_i && sb[d].size() != 0) begin
               e = sb[d].pop_front();
               check($sformatf("d%0d_buyruk", d), cikis_buyruk[d], e.buyruk);
               check($sformatf("d%0d_pc", d), cikis_pc[d], e.pc);
               check($sformatf("d%0d_tur", d), 32'(cikis_tur[d]), 32'(e.tur));
               check($sformatf("d%0d_tahmin", d), 32'(cikis_tahmin[d]), 32'(e.tahmin));
               check($sformatf("d%0d_hedef", d), cikis_hedef[d], e.hedef);
            end
         end
      end
   end

   task automatic gonder(input logic [31:0] pc, input logic [31:0] s0, input logic [31:0] s1,
                         input logic [1:0] maske,
                         input int na, input oncoz_giris_t a0, input oncoz_giris_t a1,
                         input logic ya, input logic [31:0] ypa,
                         input int nb, input oncoz_giris_t b0, input oncoz_giris_t b1,
                         input logic yb, input logic [31:0] ypb);
      bit kabul = 1'b0;
      paket_gecerli_i = 1'b1;
      paket_pc_i      = pc;
      paket_buyruk_i  = {s1, s0};
      paket_maske_i   = maske;
      for (int i = 0; i < 50 && !kabul; i++) begin
         @(negedge clk);
         #1;
         if (paket_hazir[0]) begin
            kabul = 1'b1;
            if (na > 0) sb[0].push_back(a0);
            if (na > 1) sb[0].push_back(a1);
            if (nb > 0) sb[1].push_back(b0);
            if (nb > 1) sb[1].push_back(b1);
            yon_sonraki[0] = ya;  yon_sonraki_pc[0] = ypa;
            yon_sonraki[1] = yb;  yon_sonraki_pc[1] = ypb;
            @(posedge clk);
            #1;
         end
      end
      paket_gecerli_i = 1'b0;
      if (!kabul) begin
         karsilastirilan++;
         uyusmayan++;
         $display("FAIL kabul_zaman_asimi: packet pc=%h not accepted within 50 cycles", pc);
      end
   endtask

   task automatic gonder_ayni(input logic [31:0] pc, input logic [31:0] s0, input logic [31:0] s1,
                              input logic [1:0] maske, input int n,
                              input oncoz_giris_t e0, input oncoz_giris_t e1,
                              input logic y, input logic [31:0] yp);
      gonder(pc, s0, s1, maske, n, e0, e1, y, yp, n, e0, e1, y, yp);
   endtask

   task automatic bosalt();
      int i = 0;
      while ((sb[0].size() != 0 || sb[1].size() != 0) && i < 100) begin
         @(posedge clk);
         i++;
      end
      #1;
      if (i >= 100) begin
         karsilastirilan++;
         uyusmayan++;
         $display("FAIL bosalt_zaman_asimi: left a=%0d b=%0d entries", sb[0].size(), sb[1].size());
      end
   endtask

   initial begin
      rst_i           = 1'b1;
      temizle_i       = 1'b0;
      paket_gecerli_i = 1'b0;
      paket_pc_i      = '0;
      paket_buyruk_i  = '0;
      paket_maske_i   = '0;
      cikis_hazir_i   = 1'b1;
      yon_sonraki     = '{default: 1'b0};
      yon_sonraki_pc  = '{default: 32'h0};
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      // nop + ret
      gonder_ayni(32'h100, 32'h00000013, 32'h00008067, 2'b11, 2,
                  g(32'h00000013, 32'h100, DALLANMA_YOK, 1'b0, 32'h0),
                  g(32'h00008067, 32'h104, JALR, 1'b0, 32'h0), 1'b0, 32'h0);
      // jal +8 in slot 0 kills slot 1
      gonder_ayni(32'h200, 32'h0080006F, 32'h00000013, 2'b11, 1,
                  g(32'h0080006F, 32'h200, JAL, 1'b1, 32'h208), BOS, 1'b1, 32'h208);
      // beq -4: taken only with BTFN
      gonder(32'h300, 32'h00000013, 32'hFE000EE3, 2'b11,
             2, g(32'h00000013, 32'h300, DALLANMA_YOK, 1'b0, 32'h0),
                g(32'hFE000EE3, 32'h304, DALLANMA, 1'b1, 32'h300), 1'b1, 32'h300,
             2, g(32'h00000013, 32'h300, DALLANMA_YOK, 1'b0, 32'h0),
                g(32'hFE000EE3, 32'h304, DALLANMA, 1'b0, 32'h0), 1'b0, 32'h0);
      // forward beq +8 in slot 1 only
      gonder_ayni(32'h400, 32'h00000013, 32'h00000463, 2'b10, 1,
                  g(32'h00000463, 32'h404, DALLANMA, 1'b0, 32'h0), BOS, 1'b0, 32'h0);
      // empty mask, including a masked jal
      gonder_ayni(32'h480, 32'h0080006F, 32'h0080006F, 2'b00, 0, BOS, BOS, 1'b0, 32'h0);
      gonder_ayni(32'h500, 32'h00000013, 32'h0080006F, 2'b01, 1,
                  g(32'h00000013, 32'h500, DALLANMA_YOK, 1'b0, 32'h0), BOS, 1'b0, 32'h0);
      // jal -8 in slot 1
      gonder_ayni(32'h600, 32'h00000013, 32'hFF9FF06F, 2'b11, 2,
                  g(32'h00000013, 32'h600, DALLANMA_YOK, 1'b0, 32'h0),
                  g(32'hFF9FF06F, 32'h604, JAL, 1'b1, 32'h5FC), 1'b1, 32'h5FC);
      // slot PC wraps past 2^32
      gonder_ayni(32'hFFFFFFFC, 32'h00000013, 32'h00100093, 2'b11, 2,
                  g(32'h00000013, 32'hFFFFFFFC, DALLANMA_YOK, 1'b0, 32'h0),
                  g(32'h00100093, 32'h00000000, DALLANMA_YOK, 1'b0, 32'h0), 1'b0, 32'h0);
      // beq -4 then jal: first taken slot wins under BTFN
      gonder(32'h700, 32'hFE000EE3, 32'h0080006F, 2'b11,
             1, g(32'hFE000EE3, 32'h700, DALLANMA, 1'b1, 32'h6FC), BOS, 1'b1, 32'h6FC,
             2, g(32'hFE000EE3, 32'h700, DALLANMA, 1'b0, 32'h0),
                g(32'h0080006F, 32'h704, JAL, 1'b1, 32'h70C), 1'b1, 32'h70C);
      bosalt();

      // Fill to DERINLIK across the pointer wrap, try a packet while full, then drain two.
      cikis_hazir_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         gonder_ayni(32'h1000 + 32'(8 * k), {12'(2 * k), 20'h00013}, {12'(2 * k + 1), 20'h00013}, 2'b11, 2,
                     g({12'(2 * k), 20'h00013}, 32'h1000 + 32'(8 * k), DALLANMA_YOK, 1'b0, 32'h0),
                     g({12'(2 * k + 1), 20'h00013}, 32'h1004 + 32'(8 * k), DALLANMA_YOK, 1'b0, 32'h0),
                     1'b0, 32'h0);
      end
      paket_gecerli_i = 1'b1;
      paket_pc_i      = 32'h1800;
      paket_buyruk_i  = {32'h00000013, 32'h0080006F};
      paket_maske_i   = 2'b11;
      repeat (2) @(posedge clk);
      #1 paket_gecerli_i = 1'b0;
      cikis_hazir_i = 1'b1;
      repeat (2) @(posedge clk);
      #1 cikis_hazir_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 cikis_hazir_i = 1'b1;
      bosalt();

      // Five queued entries, then flush alongside a jal packet.
      cikis_hazir_i = 1'b0;
      gonder_ayni(32'h2000, 32'h00000013, 32'h00100093, 2'b11, 2,
                  g(32'h00000013, 32'h2000, DALLANMA_YOK, 1'b0, 32'h0),
                  g(32'h00100093, 32'h2004, DALLANMA_YOK, 1'b0, 32'h0), 1'b0, 32'h0);
      gonder_ayni(32'h2008, 32'h00200113, 32'h00300193, 2'b11, 2,
                  g(32'h00200113, 32'h2008, DALLANMA_YOK, 1'b0, 32'h0),
                  g(32'h00300193, 32'h200C, DALLANMA_YOK, 1'b0, 32'h0), 1'b0, 32'h0);
      gonder_ayni(32'h2010, 32'h00400213, 32'h00000013, 2'b01, 1,
                  g(32'h00400213, 32'h2010, DALLANMA_YOK, 1'b0, 32'h0), BOS, 1'b0, 32'h0);
      temizle_i       = 1'b1;
      paket_gecerli_i = 1'b1;
      paket_pc_i      = 32'h3000;
      paket_buyruk_i  = {32'h00000013, 32'h0080006F};
      paket_maske_i   = 2'b11;
      @(negedge clk);
      #1 check("temizle_paket_hazir", 32'(paket_hazir[0]), 32'h0);
      @(posedge clk);
      #1;
      temizle_i       = 1'b0;
      paket_gecerli_i = 1'b0;
      cikis_hazir_i   = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      gonder_ayni(32'h4000, 32'h00000013, 32'h00008067, 2'b11, 2,
                  g(32'h00000013, 32'h4000, DALLANMA_YOK, 1'b0, 32'h0),
                  g(32'h00008067, 32'h4004, JALR, 1'b0, 32'h0), 1'b0, 32'h0);
      bosalt();
      repeat (3) @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", karsilastirilan, uyusmayan);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
